// File: rtl/crm_if.sv
// rtl/crm_if.sv - CRM execute/diagnostic-load port bundle
// master drives addresses and load chunks; slave (crm) returns CR and load status.
interface crm_if #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 84
);
  logic [ADDR_W-1:0] CRADR;
  logic              crEn;
  logic              diagAdrLoad;
  logic              diagValid;
  logic [35:0]       diagData;
  logic              diagReady;
  logic [ADDR_W-1:0] diagAdr;
  logic [WORD_W-1:0] cr;
  logic              crParErr;

  modport master (
    output CRADR, crEn, diagAdrLoad, diagValid, diagData,
    input  diagReady, diagAdr, cr, crParErr
  );

  modport slave (
    input  CRADR, crEn, diagAdrLoad, diagValid, diagData,
    output diagReady, diagAdr, cr, crParErr
  );
endinterface

// File: rtl/crm.sv
// rtl/crm.sv - KL10 control RAM: microword store, CR register, diagnostic load sequencer
// Define CRM_PARITY_EN to add one odd-parity bit per entry and drive crParErr.
module crm #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 84
) (
  input logic  clk,
  input logic  reset,
  crm_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LO_W  = WORD_W - 72;

  typedef enum logic [1:0] {IDLE, C1, C2, COMMIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] diag_adr_q;
  logic [ADDR_W-1:0] diag_adr_nxt;
  logic              ready_q;
  logic              accept;
  logic              commit;
  logic [35:0]       hi_q;
  logic [35:0]       mid_q;
  logic [LO_W-1:0]   lo_q;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] cr_q;
  logic              par_err_q;

  // An address load preempts a chunk offered in the same cycle.
  assign accept   = bus.diagValid & ready_q & ~bus.diagAdrLoad;
  assign commit   = (state == COMMIT) & ~reset;
  assign asm_word = {hi_q, mid_q, lo_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      diag_adr_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state      <= state_nxt;
      diag_adr_q <= diag_adr_nxt;
      ready_q    <= (state_nxt != COMMIT);
    end
  end

  always_comb begin
    state_nxt    = state;
    diag_adr_nxt = diag_adr_q;
    case (state)
      IDLE:    if (accept) state_nxt = C1;
      C1:      if (accept) state_nxt = C2;
      C2:      if (accept) state_nxt = COMMIT;
      COMMIT: begin
        state_nxt    = IDLE;
        diag_adr_nxt = diag_adr_q + ADDR_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // The commit still lands at the old address; the loaded one is not bumped.
    if (bus.diagAdrLoad) begin
      state_nxt    = IDLE;
      diag_adr_nxt = bus.diagData[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        IDLE:    hi_q  <= bus.diagData;
        C1:      mid_q <= bus.diagData;
        C2:      lo_q  <= bus.diagData[35 -: LO_W];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit)
      mem[diag_adr_q] <= asm_word;
  end

  // Read-first: a same-edge commit to CRADR is not seen until the next read.
  always_ff @(posedge clk) begin
    if (reset)
      cr_q <= '0;
    else if (bus.crEn)
      cr_q <= mem[bus.CRADR];
  end

`ifdef CRM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (commit)
      par_mem[diag_adr_q] <= ~^asm_word;
  end

  always_ff @(posedge clk) begin
    if (reset)
      par_err_q <= 1'b0;
    else if (bus.crEn)
      par_err_q <= ~^{par_mem[bus.CRADR], mem[bus.CRADR]};
  end
`else
  assign par_err_q = 1'b0;
`endif

  assign bus.diagReady = ready_q;
  assign bus.diagAdr   = diag_adr_q;
  assign bus.cr        = cr_q;
  assign bus.crParErr  = par_err_q;
endmodule
